// File: rtl/nlc_pkg.sv
// Shared types and helpers for the nested loop sequencer and its counters.
package nlc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // $clog2 that never returns 0, so a range of one value still gets a 1-bit port.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/nested_loop_ctrl_counter.sv
// Wrapping up-counter: advances on inc, wraps MAX_COUNT -> 0, flags overflow on the wrapping inc.
module counter
    import nlc_pkg::*;
#(
    parameter  int MAX_COUNT = 7,
    localparam int W         = clog2_min1(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] out,
    output logic         overflow
);

    localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNT);

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (inc) begin
            out_d = (out_q == MAX_VAL) ? '0 : out_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out      = out_q;
    assign overflow = inc && (out_q == MAX_VAL);

endmodule

// File: rtl/nested_loop_ctrl.sv
// Two-level row-major index sequencer driving an inner and an outer wrapping counter,
// presenting each (outer, inner) pair on a valid/ready stream.
module nested_loop_ctrl
    import nlc_pkg::*;
#(
    parameter  int OUTER_MAX = 3,
    parameter  int INNER_MAX = 7,
    localparam int OW        = clog2_min1(OUTER_MAX + 1),
    localparam int IW        = clog2_min1(INNER_MAX + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic [OW-1:0] outer_idx,
    output logic [IW-1:0] inner_idx,
    output logic          last
);

    localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER_MAX);
    localparam logic [IW-1:0] INNER_LAST = IW'(INNER_MAX);

    state_t        state_q;
    state_t        state_d;
    logic          clear;
    logic          handshake;
    logic          cnt_rstn;
    logic          inner_inc;
    logic          outer_inc;
    logic          inner_ovf;
    logic          outer_ovf;
    logic [IW-1:0] inner_out;
    logic [OW-1:0] outer_out;

    // The outer counter only overflows on a handshake at (OUTER_MAX, INNER_MAX),
    // so its overflow is exactly the final-handshake event.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (outer_ovf) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign idx_valid = (state_q == RUN);
    assign handshake = idx_valid && idx_ready;
    assign inner_inc = handshake;
    assign outer_inc = handshake && inner_ovf;
    assign cnt_rstn  = rstn && !clear;

    counter #(.MAX_COUNT(INNER_MAX)) u_inner (
        .clk      (clk),
        .rstn     (cnt_rstn),
        .inc      (inner_inc),
        .out      (inner_out),
        .overflow (inner_ovf)
    );

    counter #(.MAX_COUNT(OUTER_MAX)) u_outer (
        .clk      (clk),
        .rstn     (cnt_rstn),
        .inc      (outer_inc),
        .out      (outer_out),
        .overflow (outer_ovf)
    );

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign outer_idx = outer_out;
    assign inner_idx = inner_out;
    assign last      = idx_valid && (inner_out == INNER_LAST) && (outer_out == OUTER_LAST);

endmodule

// File: tb/tb_nested_loop_ctrl.sv
// Scoreboard bench for nested_loop_ctrl: three parameterisations, expected pairs queued
// at start time and popped by a monitor on every accepted beat.
module tb_nested_loop_ctrl;

    typedef struct packed {
        logic [1:0] o;
        logic [2:0] i;
        logic       l;
    } pair_t;

    logic       clk;
    logic       rstn_s  [3];
    logic       start_s [3];
    logic       ready_s [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       valid_w [3];
    logic       last_w  [3];
    logic [1:0] outer_w [3];
    logic [2:0] inner_w [3];

    logic [1:0] o0;
    logic [2:0] i0;
    logic [0:0] o1;
    logic [0:0] i1;
    logic [1:0] o2;
    logic [2:0] i2;

    pair_t exp_q [3][$];
    int    n_cmp;
    int    n_fail;
    int    beat_cnt   [3];
    int    done_cnt   [3];
    int    busy_cnt   [3];
    logic  prev_final [3];
    int    omax [3] = '{3, 0, 2};
    int    imax [3] = '{7, 0, 4};

    nested_loop_ctrl #(.OUTER_MAX(3), .INNER_MAX(7)) u_dut0 (
        .clk(clk), .rstn(rstn_s[0]), .start(start_s[0]), .busy(busy_w[0]), .done(done_w[0]),
        .idx_valid(valid_w[0]), .idx_ready(ready_s[0]), .outer_idx(o0), .inner_idx(i0),
        .last(last_w[0])
    );

    nested_loop_ctrl #(.OUTER_MAX(0), .INNER_MAX(0)) u_dut1 (
        .clk(clk), .rstn(rstn_s[1]), .start(start_s[1]), .busy(busy_w[1]), .done(done_w[1]),
        .idx_valid(valid_w[1]), .idx_ready(ready_s[1]), .outer_idx(o1), .inner_idx(i1),
        .last(last_w[1])
    );

    nested_loop_ctrl #(.OUTER_MAX(2), .INNER_MAX(4)) u_dut2 (
        .clk(clk), .rstn(rstn_s[2]), .start(start_s[2]), .busy(busy_w[2]), .done(done_w[2]),
        .idx_valid(valid_w[2]), .idx_ready(ready_s[2]), .outer_idx(o2), .inner_idx(i2),
        .last(last_w[2])
    );

    always_comb begin
        outer_w[0] = o0;
        inner_w[0] = i0;
        outer_w[1] = {1'b0, o1};
        inner_w[1] = {2'b00, i1};
        outer_w[2] = o2;
        inner_w[2] = i2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every presented pair must equal the queue head; it is only consumed on an accepted beat.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("done_timing_d%0d", d), int'(done_w[d]), int'(prev_final[d]));
            prev_final[d] = 1'b0;
            if (done_w[d]) done_cnt[d]++;
            if (busy_w[d]) busy_cnt[d]++;
            if (valid_w[d]) begin : chk
                pair_t e;
                pair_t a;
                a = '{o: outer_w[d], i: inner_w[d], l: last_w[d]};
                if (exp_q[d].size() == 0) begin
                    checkOutput($sformatf("unexpected_beat_d%0d", d), int'(a), -1);
                end else begin
                    e = exp_q[d][0];
                    checkOutput($sformatf("pair_d%0d", d), int'(a), int'(e));
                    if (ready_s[d] && rstn_s[d]) begin
                        void'(exp_q[d].pop_front());
                        beat_cnt[d]++;
                        prev_final[d] = e.l;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCounts(input int d);
        beat_cnt[d] = 0;
        done_cnt[d] = 0;
        busy_cnt[d] = 0;
    endtask

    task automatic checkReset(input int d);
        checkOutput($sformatf("rst_valid_d%0d", d), int'(valid_w[d]), 0);
        checkOutput($sformatf("rst_busy_d%0d", d),  int'(busy_w[d]), 0);
        checkOutput($sformatf("rst_done_d%0d", d),  int'(done_w[d]), 0);
        checkOutput($sformatf("rst_last_d%0d", d),  int'(last_w[d]), 0);
        checkOutput($sformatf("rst_outer_d%0d", d), int'(outer_w[d]), 0);
        checkOutput($sformatf("rst_inner_d%0d", d), int'(inner_w[d]), 0);
    endtask

    // Queue one full row-major sweep, pulse start, and check (0,0) appears the next cycle.
    task automatic applyStimulus(input int d);
        for (int o = 0; o <= omax[d]; o++) begin
            for (int i = 0; i <= imax[d]; i++) begin
                exp_q[d].push_back('{o: 2'(o), i: 3'(i), l: (o == omax[d] && i == imax[d])});
            end
        end
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
        checkOutput($sformatf("first_valid_d%0d", d), int'(valid_w[d]), 1);
        checkOutput($sformatf("first_pair_d%0d", d), int'({outer_w[d], inner_w[d]}), 0);
    endtask

    task automatic waitDone(input int d, input int budget, input bit random_ready);
        int  base;
        bit  seen;
        base = done_cnt[d];
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (random_ready) ready_s[d] = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt[d] != base) seen = 1'b1;
        end
        ready_s[d] = 1'b1;
        checkOutput($sformatf("done_seen_d%0d", d), int'(seen), 1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int d = 0; d < 3; d++) begin
            rstn_s[d]     = 1'b0;
            start_s[d]    = 1'b0;
            ready_s[d]    = 1'b1;
            prev_final[d] = 1'b0;
            clearCounts(d);
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) checkReset(d);
        for (int d = 0; d < 3; d++) rstn_s[d] = 1'b1;
        tick();

        $display("[TB] full sweep, ready held high");
        clearCounts(0);
        applyStimulus(0);
        waitDone(0, 100, 1'b0);
        checkOutput("t1_beats", beat_cnt[0], 32);
        checkOutput("t1_dones", done_cnt[0], 1);
        checkOutput("t1_busy_cycles", busy_cnt[0], 33);
        checkOutput("t1_busy_after", int'(busy_w[0]), 0);
        checkOutput("t1_queue_left", exp_q[0].size(), 0);

        $display("[TB] full sweep, random backpressure");
        clearCounts(0);
        applyStimulus(0);
        waitDone(0, 1000, 1'b1);
        checkOutput("t2_beats", beat_cnt[0], 32);
        checkOutput("t2_dones", done_cnt[0], 1);
        checkOutput("t2_queue_left", exp_q[0].size(), 0);

        $display("[TB] start ignored during RUN and DONE");
        clearCounts(0);
        applyStimulus(0);
        repeat (10) tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (21) tick();
        checkOutput("t3_in_done", int'(done_w[0]), 1);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        checkOutput("t3_idle_valid", int'(valid_w[0]), 0);
        tick();
        checkOutput("t3_still_idle", int'(busy_w[0]), 0);
        checkOutput("t3_beats", beat_cnt[0], 32);
        checkOutput("t3_dones", done_cnt[0], 1);

        $display("[TB] reset mid-sweep at (1,5)");
        clearCounts(0);
        applyStimulus(0);
        repeat (13) tick();
        checkOutput("t4_pair_at_reset", int'({outer_w[0], inner_w[0]}), int'({2'd1, 3'd5}));
        rstn_s[0] = 1'b0;
        tick();
        checkReset(0);
        rstn_s[0] = 1'b1;
        exp_q[0].delete();
        checkOutput("t4_beats_before", beat_cnt[0], 13);
        checkOutput("t4_no_done", done_cnt[0], 0);
        tick();
        clearCounts(0);
        applyStimulus(0);
        waitDone(0, 100, 1'b0);
        checkOutput("t4_beats", beat_cnt[0], 32);
        checkOutput("t4_dones", done_cnt[0], 1);

        $display("[TB] single-beat sweep");
        clearCounts(1);
        applyStimulus(1);
        checkOutput("t5_last", int'(last_w[1]), 1);
        waitDone(1, 10, 1'b0);
        checkOutput("t5_beats", beat_cnt[1], 1);
        checkOutput("t5_dones", done_cnt[1], 1);

        $display("[TB] back-to-back 3x5 sweeps");
        clearCounts(2);
        applyStimulus(2);
        waitDone(2, 50, 1'b0);
        applyStimulus(2);
        waitDone(2, 50, 1'b0);
        checkOutput("t6_beats", beat_cnt[2], 30);
        checkOutput("t6_dones", done_cnt[2], 2);
        checkOutput("t6_queue_left", exp_q[2].size(), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nested_loop_ctrl.md
# nested_loop_ctrl

Two-level loop sequencer that walks an (outer, inner) index space in row-major order and presents each index pair on a valid/ready stream. It sits directly upstream of the team's `counter` block: it generates the `inc` strobes that advance the inner and outer counters, and consumes their `out`/`overflow` results. The index stream drives tile address generation for the matmul/attention datapath.

## Interface
Parameters:
- `OUTER_MAX`, default 3: last outer index (inclusive); outer range 0..OUTER_MAX.
- `INNER_MAX`, default 7: last inner index (inclusive); inner range 0..INNER_MAX.
- `OW`: localparam, `$clog2(OUTER_MAX+1)`, minimum 1.
- `IW`: localparam, `$clog2(INNER_MAX+1)`, minimum 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: request one full sweep; sampled only in IDLE.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse after the final index handshake.
- `idx_valid` out 1: an index pair is presented.
- `idx_ready` in 1: downstream accepts the pair.
- `outer_idx` out OW: current outer index.
- `inner_idx` out IW: current inner index.
- `last` out 1: high with `idx_valid` on the final pair (OUTER_MAX, INNER_MAX).

## Operation
- FSM states and transitions:
  - IDLE: `start` moves to RUN.
  - RUN: the final handshake moves to DONE.
  - DONE: always moves to IDLE after one cycle.
- Handshake: a beat transfers when `idx_valid && idx_ready`.
  - `idx_valid` = (state == RUN).
  - While `idx_valid` is high and `idx_ready` is low, `outer_idx`, `inner_idx` and `last` hold stable.
- Counter drive:
  - Inner counter: `inc` = handshake.
  - Outer counter: `inc` = handshake && inner `overflow`.
- Counter contract, which both instances must meet:
  - `out` increments on `inc`.
  - `out` wraps from MAX_COUNT to 0.
  - `overflow` is high when `out == MAX_COUNT && inc`.
- Clearing:
  - Both counters are cleared on the `start` acceptance cycle through their `rstn` input, driven as `rstn && !clear`.
  - Every sweep therefore begins at (0,0) regardless of prior state.
- `last` = RUN && inner `out` == INNER_MAX && outer `out` == OUTER_MAX.
- A final handshake is a handshake with `last` high.
- Total beats per sweep: (OUTER_MAX+1)*(INNER_MAX+1).
- Boundary behaviour:
  - `start` during RUN or DONE is ignored; it is not queued.
  - `start` in the same cycle as `done` is ignored, because the state is DONE.
  - `idx_ready` high while `idx_valid` is low has no effect; the counters do not move.
  - Inner wrap: the pair after (o, INNER_MAX) is (o+1, 0).
  - The final wrap returns both counters to (0,0) in DONE.
  - OUTER_MAX = 0 or INNER_MAX = 0 is legal. With both 0, the sweep is a single beat with `last` = 1.
  - `rstn` low mid-sweep: the next cycle is IDLE with all outputs at reset values. The sweep is abandoned and `done` is not pulsed.

## Timing
- Reset values:
  - state = IDLE.
  - `busy` = 0, `done` = 0, `idx_valid` = 0, `last` = 0.
  - `outer_idx` = 0, `inner_idx` = 0.
- Latency:
  - `start` sampled in IDLE at edge N gives `idx_valid` = 1 with (0,0) in cycle N+1.
  - With `idx_ready` held high, one beat transfers per cycle and there are no bubbles, including across an inner wrap.
  - Final handshake at edge M gives `done` = 1 and `busy` = 1 in cycle M+1, and `idx_valid` = 0.
  - In cycle M+2 the block is IDLE with `busy` = 0.
- Minimum start-to-start spacing is beats + 2 cycles.
- All outputs are registered or decoded from registered state and counter outputs.
- No combinational path runs from `idx_ready` to `idx_valid`.

## Structure
- Package `nlc_pkg` holds:
  - the state enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - the width helper function for minimum-1 `$clog2`.
- Sub-module: two instances of the existing `counter`:
  - `u_inner` with MAX_COUNT = INNER_MAX;
  - `u_outer` with MAX_COUNT = OUTER_MAX.
- The top level contains only the FSM, clear and inc decode, and `last`/`done` logic.

## Test plan
- Default parameters, pulse `start`, `idx_ready` = 1:
  - 32 consecutive beats: (0,0),(0,1)…(0,7),(1,0)…(3,7);
  - `last` only on (3,7);
  - `done` pulses one cycle later;
  - `busy` is high for 33 cycles.
- Backpressure: `idx_ready` random at 50%:
  - same 32-pair sequence;
  - index outputs held stable while stalled;
  - no beat dropped or duplicated.
- `start` pulsed at beat 10 of RUN and in the DONE cycle: both ignored, with exactly one sweep and one `done`.
- `rstn` low for 1 cycle at beat 13 (index (1,5)), then `start`: outputs go to reset values, and the new sweep begins at (0,0) with 32 beats.
- Parameters OUTER_MAX = 0, INNER_MAX = 0:
  - `start` gives one beat (0,0) with `last` = 1;
  - `done` follows the next cycle.
- Parameters OUTER_MAX = 2, INNER_MAX = 4, two back-to-back sweeps: 15 beats each, and the second sweep starts at (0,0).
